// File: rtl/move_cmd_gen_if.sv
// Button / command bundle between the input front end and the game core.
// The command generator uses the slave view; whoever drives the buttons and
// consumes the commands (game core, bench) uses the master view.
interface move_cmd_gen_if;
  logic         btn_left;
  logic         btn_right;
  logic         btn_up;
  logic         btn_down;
  logic         piece_landed;
  logic         leftSignal;
  logic         rightSignal;
  logic         upSignal;
  logic         downSignal;
  logic [144:0] initialSquare;

  modport master (
    output btn_left, btn_right, btn_up, btn_down, piece_landed,
    input  leftSignal, rightSignal, upSignal, downSignal, initialSquare
  );

  modport slave (
    input  btn_left, btn_right, btn_up, btn_down, piece_landed,
    output leftSignal, rightSignal, upSignal, downSignal, initialSquare
  );
endinterface

// File: rtl/move_cmd_gen.sv
// Move command generator: synchronizes and debounces four push buttons,
// auto-repeats left/right/down, injects gravity down requests, arbitrates
// one command pulse at a time (up > left > right > down, idle cycle between
// pulses) and picks the spawn mask of the next piece from a 7-bit LFSR.
// Direction index used throughout: 0 left, 1 right, 2 up, 3 down.
module move_cmd_gen #(
  parameter int DEB_LIMIT      = 1000000,
  parameter int REPEAT_DELAY   = 30000000,
  parameter int REPEAT_PERIOD  = 10000000,
  parameter int GRAVITY_PERIOD = 50000000
) (
  input logic          clk,
  input logic          reset,
  move_cmd_gen_if.slave bus
);

  localparam int DIR_L = 0;
  localparam int DIR_R = 1;
  localparam int DIR_U = 2;
  localparam int DIR_D = 3;

  // Up (rotate) never auto-repeats.
  localparam logic [3:0] REPEAT_MASK = 4'b1011;

  localparam int DW   = (DEB_LIMIT > 2) ? $clog2(DEB_LIMIT) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
  localparam int GW   = (GRAVITY_PERIOD > 2) ? $clog2(GRAVITY_PERIOD) : 1;

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_LIMIT - 1);
  localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST  = RW'(REPEAT_PERIOD - 1);
  // The counter "reaches" GRAVITY_PERIOD-1 on the edge where it would be
  // written with that value, so the hit is detected one count earlier and the
  // counter is cleared instead; this gives exactly GRAVITY_PERIOD cycles
  // between idle gravity pulses.
  localparam logic [GW-1:0] GRAV_HIT = GW'(GRAVITY_PERIOD - 2);

  localparam logic [144:0] SHAPE_T = 145'h20070;

  // Spawn mask lookup; unused LFSR code 7 folds onto the I piece.
  function automatic logic [144:0] shapeMask(input logic [2:0] idx);
    logic [144:0] m;
    case (idx)
      3'd0:    m = 145'h000F0;  // I {4,5,6,7}
      3'd1:    m = 145'h60060;  // O {5,6,17,18}
      3'd2:    m = 145'h20070;  // T {4,5,6,17}
      3'd3:    m = 145'h30060;  // S {5,6,16,17}
      3'd4:    m = 145'h60030;  // Z {4,5,17,18}
      3'd5:    m = 145'h40070;  // J {4,5,6,18}
      3'd6:    m = 145'h10070;  // L {4,5,6,16}
      default: m = 145'h000F0;  // 7 -> I
    endcase
    return m;
  endfunction

  // Fibonacci LFSR step for x^7 + x^6 + 1.
  function automatic logic [6:0] lfsrStep(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  logic [3:0]    btnRaw_s;
  logic [3:0]    syncA_r;
  logic [3:0]    syncB_r;
  logic [3:0]    deb_r;
  logic [DW-1:0] debCnt_r [4];
  logic [RW-1:0] rptCnt_r [4];
  logic [3:0]    rptFirst_r;
  logic [3:0]    pend_r;
  logic [3:0]    pulse_r;
  logic          landedHold_r;
  logic [GW-1:0] grav_r;
  logic [6:0]    lfsr_r;
  logic [144:0]  square_r;

  logic [3:0]    debFlip_s;
  logic [3:0]    edgeReq_s;
  logic [3:0]    rptHit_s;
  logic          gravHit_s;
  logic [3:0]    req_s;
  logic          canIssue_s;
  logic [3:0]    issue_s;
  logic [3:0]    pendNext_s;
  logic          gravClear_s;

  // Request sources: debounced rising edges, repeat timer hits, gravity expiry
  always_comb begin
    btnRaw_s  = {bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left};
    debFlip_s = 4'b0000;
    edgeReq_s = 4'b0000;
    rptHit_s  = 4'b0000;
    for (int d = 0; d < 4; d++) begin
      if ((syncB_r[d] != deb_r[d]) && (debCnt_r[d] == DEB_LAST)) begin
        debFlip_s[d] = 1'b1;
      end else begin
        debFlip_s[d] = 1'b0;
      end
      edgeReq_s[d] = debFlip_s[d] & syncB_r[d];
      if (REPEAT_MASK[d] && deb_r[d]) begin
        if (rptFirst_r[d]) begin
          rptHit_s[d] = (rptCnt_r[d] == RP_LAST);
        end else begin
          rptHit_s[d] = (rptCnt_r[d] == RD_LAST);
        end
      end else begin
        rptHit_s[d] = 1'b0;
      end
    end
    gravHit_s = (grav_r == GRAV_HIT);
    req_s     = edgeReq_s | rptHit_s | {gravHit_s, 3'b000};
  end

  // Arbitration: one pulse at a time, idle cycle after each pulse and a
  // two-cycle blackout around a landing; lower-priority flags stay pending
  always_comb begin
    canIssue_s = ~bus.piece_landed & ~landedHold_r & (pulse_r == 4'b0000);
    issue_s    = 4'b0000;
    if (canIssue_s) begin
      casez (pend_r)
        4'b?1??: issue_s = 4'b0100;  // up
        4'b?0?1: issue_s = 4'b0001;  // left
        4'b?010: issue_s = 4'b0010;  // right
        4'b1000: issue_s = 4'b1000;  // down
        default: issue_s = 4'b0000;
      endcase
    end else begin
      issue_s = 4'b0000;
    end
    // A request landing on an already pending direction simply merges.
    if (bus.piece_landed) begin
      pendNext_s = 4'b0000;
    end else begin
      pendNext_s = (pend_r | req_s) & ~issue_s;
    end
    gravClear_s = bus.piece_landed | issue_s[DIR_D] | gravHit_s;
  end

  // Two-flop synchronizers bring the raw buttons into the clock domain
  always_ff @(posedge clk) begin
    if (reset) begin
      syncA_r <= 4'b0000;
      syncB_r <= 4'b0000;
    end else begin
      syncA_r <= btnRaw_s;
      syncB_r <= syncA_r;
    end
  end

  // Debounce: adopt the synchronized level after DEB_LIMIT disagreeing cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_r <= 4'b0000;
      for (int d = 0; d < 4; d++) begin
        debCnt_r[d] <= {DW{1'b0}};
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (debFlip_s[d]) begin
          deb_r[d]    <= syncB_r[d];
          debCnt_r[d] <= {DW{1'b0}};
        end else if (syncB_r[d] != deb_r[d]) begin
          debCnt_r[d] <= debCnt_r[d] + DW'(1);
        end else begin
          debCnt_r[d] <= {DW{1'b0}};
        end
      end
    end
  end

  // Auto-repeat timers run only while the debounced level is held high
  always_ff @(posedge clk) begin
    if (reset) begin
      rptFirst_r <= 4'b0000;
      for (int d = 0; d < 4; d++) begin
        rptCnt_r[d] <= {RW{1'b0}};
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (REPEAT_MASK[d] && deb_r[d]) begin
          if (rptHit_s[d]) begin
            rptCnt_r[d]   <= {RW{1'b0}};
            rptFirst_r[d] <= 1'b1;
          end else begin
            rptCnt_r[d] <= rptCnt_r[d] + RW'(1);
          end
        end else begin
          rptCnt_r[d]   <= {RW{1'b0}};
          rptFirst_r[d] <= 1'b0;
        end
      end
    end
  end

  // Pending flags, registered command pulses and the post-landing blackout
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r       <= 4'b0000;
      pulse_r      <= 4'b0000;
      landedHold_r <= 1'b0;
    end else begin
      pend_r       <= pendNext_s;
      pulse_r      <= issue_s;
      landedHold_r <= bus.piece_landed;
    end
  end

  // Gravity timer restarts on expiry, on any issued down and on a landing
  always_ff @(posedge clk) begin
    if (reset) begin
      grav_r <= {GW{1'b0}};
    end else if (gravClear_s) begin
      grav_r <= {GW{1'b0}};
    end else begin
      grav_r <= grav_r + GW'(1);
    end
  end

  // Free-running piece LFSR; the landing edge latches the next spawn mask
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r   <= 7'h01;
      square_r <= SHAPE_T;
    end else begin
      lfsr_r <= lfsrStep(lfsr_r);
      if (bus.piece_landed) begin
        square_r <= shapeMask(lfsr_r[2:0]);
      end else begin
        square_r <= square_r;
      end
    end
  end

  assign bus.leftSignal    = pulse_r[DIR_L];
  assign bus.rightSignal   = pulse_r[DIR_R];
  assign bus.upSignal      = pulse_r[DIR_U];
  assign bus.downSignal    = pulse_r[DIR_D];
  assign bus.initialSquare = square_r;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Bench for move_cmd_gen with small timing parameters. A reference model
// (integer hold ages, run lengths and idle counts) predicts every command
// pulse and pushes it into a scoreboard queue; a negedge monitor pops and
// compares whenever the DUT presents a pulse. Directed scenarios add
// latency/spacing checks on the observed pulse log.
module tb_move_cmd_gen;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;
  localparam int GP  = 50;

  typedef struct {
    int         cyc;
    logic [3:0] v;
  } pulse_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  move_cmd_gen_if bus ();

  move_cmd_gen #(
    .DEB_LIMIT(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .GRAVITY_PERIOD(GP)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  pulse_t expQ[$];
  pulse_t seen[$];

  // reference model state
  logic [3:0]   mS1, mS2, mDeb, mPend, mOut;
  int           mRun[4];
  int           mAge[4];
  int           mIdle;
  logic         mHold;
  logic [6:0]   mLfsr;
  logic [144:0] mMask;

  function automatic logic [144:0] shapeOf(input logic [2:0] i);
    int           b[4];
    logic [144:0] m;
    m = '0;
    case (i)
      3'd1:    b = '{5, 6, 17, 18};
      3'd2:    b = '{4, 5, 6, 17};
      3'd3:    b = '{5, 6, 16, 17};
      3'd4:    b = '{4, 5, 17, 18};
      3'd5:    b = '{4, 5, 6, 18};
      3'd6:    b = '{4, 5, 6, 16};
      default: b = '{4, 5, 6, 7};
    endcase
    foreach (b[k]) m[b[k]] = 1'b1;
    return m;
  endfunction

  task automatic modelStep();
    logic [3:0] btn, req, iss, nDeb;
    logic       landed;
    logic       gHit;
    cycle++;
    btn    = {bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left};
    landed = bus.piece_landed;
    if (rst) begin
      mS1 = 4'b0; mS2 = 4'b0; mDeb = 4'b0; mPend = 4'b0; mOut = 4'b0;
      mHold = 1'b0; mIdle = 0; mLfsr = 7'h01; mMask = shapeOf(3'd2);
      for (int d = 0; d < 4; d++) begin
        mRun[d] = 0;
        mAge[d] = 0;
      end
    end else begin
      req  = 4'b0;
      nDeb = mDeb;
      for (int d = 0; d < 4; d++) begin
        // auto-repeat: hold age counted in cycles since the debounced rise
        if (mDeb[d] && d != 2) begin
          mAge[d]++;
          if (mAge[d] == RD || (mAge[d] > RD && (mAge[d] - RD) % RP == 0)) req[d] = 1'b1;
        end
        // debounce: run length of disagreement between synchronized and held level
        if (mS2[d] != mDeb[d]) begin
          mRun[d]++;
          if (mRun[d] == DEB) begin
            nDeb[d] = mS2[d];
            mRun[d] = 0;
            if (mS2[d]) begin
              req[d]  = 1'b1;
              mAge[d] = 0;
            end
          end
        end else begin
          mRun[d] = 0;
        end
      end
      gHit = (mIdle + 1 == GP - 1);
      if (gHit) req[3] = 1'b1;
      iss = 4'b0;
      if (!landed && !mHold && mOut == 4'b0) begin
        if (mPend[2])      iss = 4'b0100;
        else if (mPend[0]) iss = 4'b0001;
        else if (mPend[1]) iss = 4'b0010;
        else if (mPend[3]) iss = 4'b1000;
      end
      if (landed || iss[3] || gHit) mIdle = 0;
      else mIdle++;
      mPend = landed ? 4'b0 : ((mPend | req) & ~iss);
      mOut  = iss;
      if (iss != 4'b0) expQ.push_back('{cycle, iss});
      mHold = landed;
      if (landed) mMask = shapeOf(mLfsr[2:0]);
      mLfsr = {mLfsr[5:0], mLfsr[6] ^ mLfsr[5]};
      mDeb  = nDeb;
      mS2   = mS1;
      mS1   = btn;
    end
  endtask

  task automatic monitorStep();
    logic [3:0] dv;
    dv = {bus.downSignal, bus.upSignal, bus.rightSignal, bus.leftSignal};
    while (expQ.size() > 0 && expQ[0].cyc < cycle) begin
      total++; bad++;
      $display("FAIL missing_pulse cyc=%0d got=none exp=%b", expQ[0].cyc, expQ[0].v);
      void'(expQ.pop_front());
    end
    if (dv != 4'b0) begin
      total++;
      seen.push_back('{cycle, dv});
      if (expQ.size() > 0 && expQ[0].cyc == cycle && expQ[0].v == dv) begin
        void'(expQ.pop_front());
      end else begin
        bad++;
        $display("FAIL pulse cyc=%0d got=%b exp=%b", cycle, dv,
                 (expQ.size() > 0 && expQ[0].cyc == cycle) ? expQ[0].v : 4'b0000);
        if (expQ.size() > 0 && expQ[0].cyc == cycle) void'(expQ.pop_front());
      end
    end else if (expQ.size() > 0 && expQ[0].cyc == cycle) begin
      total++; bad++;
      $display("FAIL missing_pulse cyc=%0d got=none exp=%b", cycle, expQ[0].v);
      void'(expQ.pop_front());
    end
    total++;
    if (bus.initialSquare !== mMask) begin
      bad++;
      $display("FAIL square cyc=%0d got=%h exp=%h", cycle, bus.initialSquare, mMask);
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    monitorStep();
  end

  function automatic int nthPulse(input logic [3:0] m, input int from, input int n);
    int k;
    k = 0;
    foreach (seen[i]) begin
      if ((seen[i].v & m) != 4'b0 && seen[i].cyc > from) begin
        k++;
        if (k == n) return seen[i].cyc;
      end
    end
    return -1000;
  endfunction

  function automatic int countPulses(input logic [3:0] m, input int from, input int upto);
    int k;
    k = 0;
    foreach (seen[i]) begin
      if ((seen[i].v & m) != 4'b0 && seen[i].cyc > from && seen[i].cyc <= upto) k++;
    end
    return k;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setBtn(input logic [3:0] b);
    bus.btn_left  = b[0];
    bus.btn_right = b[1];
    bus.btn_up    = b[2];
    bus.btn_down  = b[3];
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  int p, q, f, base;
  logic [3:0] rb;

  initial begin
    setBtn(4'b0000);
    bus.piece_landed = 1'b0;
    rst = 1'b1;
    tick(2);
    chk("reset_pulses", {bus.downSignal, bus.upSignal, bus.rightSignal, bus.leftSignal}, 0);
    chk("reset_square_is_T", (bus.initialSquare == 145'h20070) ? 1 : 0, 1);
    rst = 1'b0;

    // short tap never survives the debounce window
    doReset();
    base = cycle;
    setBtn(4'b0001); tick(3); setBtn(4'b0000); tick(15);
    chk("tap_no_left", countPulses(4'b0001, base, cycle), 0);

    // held left: first pulse, then repeats at +10 and +15
    doReset();
    p = cycle;
    setBtn(4'b0001); tick(18); setBtn(4'b0000); tick(30);
    f = nthPulse(4'b0001, p, 1);
    chk("hold_first_latency", f - p, 7);
    chk("hold_repeat1", nthPulse(4'b0001, p, 2) - f, 10);
    chk("hold_repeat2", nthPulse(4'b0001, p, 3) - f, 15);
    chk("hold_count", countPulses(4'b0001, p, cycle), 3);

    // up and right debounced together: up, idle cycle, right
    doReset();
    p = cycle;
    setBtn(4'b0110); tick(12); setBtn(4'b0000); tick(12);
    chk("up_latency", nthPulse(4'b0100, p, 1) - p, 7);
    chk("right_after_up", nthPulse(4'b0010, p, 1) - nthPulse(4'b0100, p, 1), 2);

    // gravity alone, then a manual down restarts the interval
    doReset();
    base = cycle;
    tick(190);
    chk("grav_first", nthPulse(4'b1000, base, 1) - base, GP);
    chk("grav_period", nthPulse(4'b1000, base, 2) - nthPulse(4'b1000, base, 1), GP);
    chk("grav_count", countPulses(4'b1000, base, cycle), 3);
    p = cycle;
    setBtn(4'b1000); tick(6); setBtn(4'b0000); tick(60);
    f = nthPulse(4'b1000, p, 1);
    chk("manual_down_latency", f - p, 7);
    chk("grav_after_manual", nthPulse(4'b1000, p, 2) - f, GP);

    // landing while left and down are both pending
    doReset();
    p = cycle;
    setBtn(4'b1001); tick(6);
    bus.piece_landed = 1'b1; tick(1);
    bus.piece_landed = 1'b0;
    chk("landed_bit144", bus.initialSquare[144], 0);
    tick(7);
    chk("landed_no_pulse", countPulses(4'b1111, p, p + 12), 0);
    tick(8);
    setBtn(4'b0000);
    chk("landed_left_repeat_only", nthPulse(4'b0001, p, 1) - p, 17);
    tick(25);

    // reset in the middle of a right hold, button still high afterwards
    doReset();
    p = cycle;
    setBtn(4'b0010); tick(8);
    rst = 1'b1; tick(3);
    chk("midreset_pulses", {bus.downSignal, bus.upSignal, bus.rightSignal, bus.leftSignal}, 0);
    chk("midreset_square", (bus.initialSquare == 145'h20070) ? 1 : 0, 1);
    rst = 1'b0;
    q = cycle;
    tick(9); setBtn(4'b0000); tick(20);
    chk("right_after_reset", nthPulse(4'b0010, q, 1) - q, 7);

    // randomized traffic: holds, glitches, landings and occasional resets
    rb = 4'b0000;
    for (int i = 0; i < 4000; i++) begin
      for (int d = 0; d < 4; d++) begin
        if ($urandom_range(0, 15) == 0) rb[d] = ~rb[d];
      end
      setBtn(rb);
      bus.piece_landed = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 799) == 0);
      tick(1);
    end
    rst = 1'b0;
    bus.piece_landed = 1'b0;
    setBtn(4'b0000);
    tick(5);
    chk("queue_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
